alu_issue_ctrl: RTL and testbench

- EX-stage issue/capture sequencer that drives MainALU's A, B and ALUControl inputs and consumes its Result.
- Accepts one decoded instruction at a time from ID/EX over a valid/ready handshake and maps the opcode to ALUControl.
- Captures Result into a one-entry EX/MEM output register with valid/ready backpressure and maintains architectural Z/N/V flags.
- Implements SWAP as a two-beat register writeback, so MainALU stays single-beat.

---
 rtl/alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// EX-stage sequencer: issues one decoded instruction to MainALU, captures its Result into a
// one-entry writeback register and maintains Z/N/V. SWAP is split into two single-beat writebacks.
module alu_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int REGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [REGW-1:0]  in_rd,
  input  logic [REGW-1:0]  in_rs,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [REGW-1:0]  out_waddr,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_SWAP = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;

  localparam logic [2:0] CTRL_ADD   = 3'b000;
  localparam logic [2:0] CTRL_SUB   = 3'b001;
  localparam logic [2:0] CTRL_MOVB  = 3'b010;
  localparam logic [2:0] CTRL_PASSA = 3'b011;
  localparam logic [2:0] CTRL_AND   = 3'b100;
  localparam logic [2:0] CTRL_OR    = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, SWAP2} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg, op_next;
  logic [REGW-1:0]  rd_reg, rd_next;
  logic [REGW-1:0]  rs_reg, rs_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [REGW-1:0]  out_waddr_reg, out_waddr_next;
  logic             flag_z_reg, flag_z_next;
  logic             flag_n_reg, flag_n_next;
  logic             flag_v_reg, flag_v_next;
  logic             err_reg, err_next;

  logic slot_free;
  logic res_z, res_n, v_add, v_sub;

  function automatic logic [2:0] op_to_ctrl(input logic [3:0] op);
    case (op)
      OP_ADD:  return CTRL_ADD;
      OP_SUB:  return CTRL_SUB;
      OP_MOV:  return CTRL_MOVB;
      OP_SWAP: return CTRL_MOVB;
      OP_AND:  return CTRL_AND;
      OP_OR:   return CTRL_OR;
      OP_CMP:  return CTRL_SUB;
      default: return CTRL_ADD;
    endcase
  endfunction

  // Flags derive from the external Result and the latched operands, not from MainALU's own flags.
  assign slot_free = ~out_valid_reg | out_ready;
  assign res_z     = (alu_result == '0);
  assign res_n     = alu_result[WIDTH-1];
  assign v_add     = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (alu_result[WIDTH-1] != a_reg[WIDTH-1]);
  assign v_sub     = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) & (alu_result[WIDTH-1] != a_reg[WIDTH-1]);

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    rd_next        = rd_reg;
    rs_next        = rs_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_waddr_next = out_waddr_reg;
    flag_z_next    = flag_z_reg;
    flag_n_next    = flag_n_reg;
    flag_v_next    = flag_v_reg;
    err_next       = 1'b0;
    in_ready       = 1'b0;
    alu_a          = '0;
    alu_b          = '0;
    alu_ctrl       = CTRL_ADD;

    // A held beat drains on its handshake; a capture below may reload it in the same edge.
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          op_next = in_op;
          rd_next = in_rd;
          rs_next = in_rs;
          a_next  = in_a;
          b_next  = in_b;
          if (in_op > OP_CMP) begin
            err_next = 1'b1;
          end else begin
            state_next = EXEC;
          end
        end
      end

      EXEC: begin
        alu_a    = a_reg;
        alu_b    = b_reg;
        alu_ctrl = op_to_ctrl(op_reg);
        if (op_reg == OP_CMP) begin
          flag_z_next = res_z;
          flag_n_next = res_n;
          flag_v_next = v_sub;
          state_next  = IDLE;
        end else if (slot_free) begin
          out_valid_next = 1'b1;
          out_data_next  = alu_result;
          out_waddr_next = rd_reg;
          case (op_reg)
            OP_ADD: begin
              flag_z_next = res_z;
              flag_n_next = res_n;
              flag_v_next = v_add;
            end
            OP_SUB: begin
              flag_z_next = res_z;
              flag_n_next = res_n;
              flag_v_next = v_sub;
            end
            OP_AND, OP_OR: begin
              flag_z_next = res_z;
              flag_n_next = res_n;
              flag_v_next = 1'b0;
            end
            default: ;
          endcase
          state_next = (op_reg == OP_SWAP) ? SWAP2 : IDLE;
        end
      end

      SWAP2: begin
        alu_a    = a_reg;
        alu_b    = b_reg;
        alu_ctrl = CTRL_PASSA;
        if (slot_free) begin
          out_valid_next = 1'b1;
          out_data_next  = alu_result;
          out_waddr_next = rs_reg;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      rd_reg        <= '0;
      rs_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_waddr_reg <= '0;
      flag_z_reg    <= 1'b0;
      flag_n_reg    <= 1'b0;
      flag_v_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      rd_reg        <= rd_next;
      rs_reg        <= rs_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_waddr_reg <= out_waddr_next;
      flag_z_reg    <= flag_z_next;
      flag_n_reg    <= flag_n_next;
      flag_v_reg    <= flag_v_next;
      err_reg       <= err_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_waddr = out_waddr_reg;
  assign flag_z    = flag_z_reg;
  assign flag_n    = flag_n_reg;
  assign flag_v    = flag_v_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural MainALU hooked to alu_a/alu_b/alu_ctrl.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_waddr;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.WIDTH(16), .REGW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs(in_rs), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_waddr(out_waddr),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  // MainALU stand-in
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_b;
      3'b011: alu_result = alu_a;
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n, input logic v);
    check_eq({tag, "_z"}, flag_z, z);
    check_eq({tag, "_n"}, flag_n, n);
    check_eq({tag, "_v"}, flag_v, v);
  endtask

  // Presents an instruction and returns at T+1 (#1 after the accepting edge).
  task automatic issue(input string tag, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [15:0] a, input logic [15:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs    = rs;
    in_a     = a;
    in_b     = b;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_eq({tag, "_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    $display("issue %s op=%0d rd=%0d rs=%0d a=%h b=%h", tag, op, rd, rs, a, b);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_alu_ctrl", alu_ctrl, 3'b000);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // ADD with signed overflow
    issue("add", 4'd0, 4'd3, 4'd0, 16'h7FFF, 16'h0001);
    check_eq("add_ctrl", alu_ctrl, 3'b000);
    check_eq("add_alu_a", alu_a, 16'h7FFF);
    check_eq("add_busy", in_ready, 1'b0);
    check_eq("add_t1_valid", out_valid, 1'b0);
    tick();
    check_eq("add_valid", out_valid, 1'b1);
    check_eq("add_data", out_data, 16'h8000);
    check_eq("add_waddr", out_waddr, 4'd3);
    check_flags("add", 1'b0, 1'b1, 1'b1);

    // asynchronous reset in the middle of a cycle
    #3 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_alu_ctrl", alu_ctrl, 3'b000);
    check_eq("arst_err", err, 1'b0);
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    check_eq("arst_in_ready", in_ready, 1'b1);

    // SWAP with flags N=1 V=1 established by an ADD
    issue("add2", 4'd0, 4'd3, 4'd0, 16'h7FFF, 16'h0001);
    tick();
    issue("swap", 4'd3, 4'd1, 4'd2, 16'h1234, 16'hABCD);
    check_eq("swap_t1_ready", in_ready, 1'b0);
    check_eq("swap_t1_ctrl", alu_ctrl, 3'b010);
    check_eq("swap_t1_valid", out_valid, 1'b0);
    tick();
    check_eq("swap_b1_valid", out_valid, 1'b1);
    check_eq("swap_b1_data", out_data, 16'hABCD);
    check_eq("swap_b1_waddr", out_waddr, 4'd1);
    check_eq("swap_t2_ready", in_ready, 1'b0);
    check_eq("swap_t2_ctrl", alu_ctrl, 3'b011);
    tick();
    check_eq("swap_b2_valid", out_valid, 1'b1);
    check_eq("swap_b2_data", out_data, 16'h1234);
    check_eq("swap_b2_waddr", out_waddr, 4'd2);
    check_flags("swap", 1'b0, 1'b1, 1'b1);

    // SUB held off behind a beat that is not drained for 4 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd1; in_rd = 4'd7; in_rs = 4'd0; in_a = 16'h0005; in_b = 16'h0007;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hold_in_ready", in_ready, 1'b0);
      check_eq("hold_data", out_data, 16'h1234);
      check_eq("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    issue("sub", 4'd1, 4'd7, 4'd0, 16'h0005, 16'h0007);
    check_eq("sub_alu_a", alu_a, 16'h0005);
    check_eq("sub_alu_b", alu_b, 16'h0007);
    check_eq("sub_ctrl", alu_ctrl, 3'b001);
    check_eq("sub_t1_valid", out_valid, 1'b0);
    tick();
    check_eq("sub_data", out_data, 16'hFFFE);
    check_eq("sub_waddr", out_waddr, 4'd7);
    check_flags("sub", 1'b0, 1'b1, 1'b0);

    // AND clears V left set by an overflowing ADD
    issue("add3", 4'd0, 4'd8, 4'd0, 16'h7FFF, 16'h0001);
    tick();
    check_eq("add3_v", flag_v, 1'b1);
    issue("and", 4'd4, 4'd9, 4'd0, 16'hF0F0, 16'h0F0F);
    tick();
    check_eq("and_data", out_data, 16'h0000);
    check_eq("and_waddr", out_waddr, 4'd9);
    check_flags("and", 1'b1, 1'b0, 1'b0);

    // CMP updates flags only, then an illegal opcode
    issue("cmp", 4'd6, 4'd10, 4'd0, 16'h0009, 16'h0009);
    check_eq("cmp_ctrl", alu_ctrl, 3'b001);
    check_eq("cmp_t1_ready", in_ready, 1'b0);
    check_eq("cmp_t1_valid", out_valid, 1'b0);
    tick();
    check_eq("cmp_t2_valid", out_valid, 1'b0);
    check_eq("cmp_t2_ready", in_ready, 1'b1);
    check_flags("cmp", 1'b1, 1'b0, 1'b0);
    issue("illegal", 4'hF, 4'd11, 4'd0, 16'h1111, 16'h2222);
    check_eq("ill_err", err, 1'b1);
    check_eq("ill_valid", out_valid, 1'b0);
    check_eq("ill_ready", in_ready, 1'b1);
    tick();
    check_eq("ill_err_clear", err, 1'b0);
    check_eq("ill_valid2", out_valid, 1'b0);
    check_eq("ill_flag_z", flag_z, 1'b1);

    // SWAP stalled after beat 1, then reset discards everything
    out_ready = 1'b0;
    issue("swap_rst", 4'd3, 4'd4, 4'd5, 16'h00AA, 16'h0055);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_data", out_data, 16'h0055);
      check_eq("stall_waddr", out_waddr, 4'd4);
      check_eq("stall_ctrl", alu_ctrl, 3'b011);
      check_eq("stall_alu_a", alu_a, 16'h00AA);
      tick();
    end
    #3 rst = 1'b1;
    #1;
    check_eq("srst_valid", out_valid, 1'b0);
    check_eq("srst_ctrl", alu_ctrl, 3'b000);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("srst_no_beat", out_valid, 1'b0);
      check_eq("srst_ready", in_ready, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
